// File: rtl/utf8_pkg.sv
// Shared types and constants for the UTF-8 character assembler: FSM states,
// byte classes, the replacement word, the Thai code-point range and the byte classifier.
package utf8_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GOT1,
        GOT2,
        REPLAY
    } state_e;

    typedef enum logic [1:0] {
        CLS_ASCII,
        CLS_LEAD3,
        CLS_CONT,
        CLS_OTHER
    } byte_cls_e;

    localparam logic [23:0] REPL_CHAR_DEF = 24'h00003F;

    // U+0E00..U+0E7F encodes as E0 B8 xx or E0 B9 xx
    localparam logic [7:0] THAI_B0    = 8'hE0;
    localparam logic [7:0] THAI_B1_LO = 8'hB8;
    localparam logic [7:0] THAI_B1_HI = 8'hB9;

    function automatic byte_cls_e classify(input logic [7:0] b);
        casez (b)
            8'b0???????: return CLS_ASCII;
            8'b1110????: return CLS_LEAD3;
            8'b10??????: return CLS_CONT;
            default:     return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/utf8_timeout_counter.sv
// Inter-byte idle counter: clear has priority over enable, tc flags TIMEOUT_CYCLES-1.
module utf8_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/utf8_char_assembler.sv
// Assembles UART bytes into 24-bit display character words (ASCII or 3-byte UTF-8).
// Define THAI_RANGE_CHECK_EN to reject 3-byte sequences outside U+0E00..U+0E7F.
module utf8_char_assembler
    import utf8_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          CNT_W          = 20,
    parameter logic [23:0] REPL_CHAR      = REPL_CHAR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [23:0] tx_data,
    output logic        tx_start,
    output logic        err_pulse,
    output logic        busy
);

    state_e      r_state;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [7:0]  r_pend;
    logic [23:0] r_tx_data;
    logic        r_tx_start;
    logic        r_err;

    state_e      w_state_nx;
    logic [7:0]  w_b0_nx;
    logic [7:0]  w_b1_nx;
    logic [7:0]  w_pend_nx;
    logic        w_emit;
    logic        w_emit_err;
    logic [23:0] w_emit_data;
    logic [7:0]  w_byte;
    byte_cls_e   w_cls;
    logic        w_busy;
    logic        w_tc;

`ifdef THAI_RANGE_CHECK_EN
    function automatic logic thai_ok(input logic [7:0] b0, input logic [7:0] b1);
        return (b0 == THAI_B0) && ((b1 == THAI_B1_LO) || (b1 == THAI_B1_HI));
    endfunction
`endif

    assign w_busy = (r_state == GOT1) || (r_state == GOT2);

    utf8_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .i_clr (rx_valid),
        .i_en  (w_busy),
        .o_tc  (w_tc)
    );

    // In REPLAY the offending byte from the previous cycle is re-run through IDLE rules
    assign w_byte = (r_state == REPLAY) ? r_pend : rx_data;
    assign w_cls  = classify(w_byte);

    always_comb begin
        w_state_nx  = r_state;
        w_b0_nx     = r_b0;
        w_b1_nx     = r_b1;
        w_pend_nx   = r_pend;
        w_emit      = 1'b0;
        w_emit_err  = 1'b0;
        w_emit_data = r_tx_data;
        case (r_state)
            IDLE, REPLAY: begin
                if (rx_valid || (r_state == REPLAY)) begin
                    w_state_nx = IDLE;
                    case (w_cls)
                        CLS_ASCII: begin
                            w_emit      = 1'b1;
                            w_emit_data = {16'h0000, w_byte};
                        end
                        CLS_LEAD3: begin
                            w_b0_nx    = w_byte;
                            w_state_nx = GOT1;
                        end
                        default: begin
                            w_emit      = 1'b1;
                            w_emit_err  = 1'b1;
                            w_emit_data = REPL_CHAR;
                        end
                    endcase
                end
            end
            GOT1, GOT2: begin
                if (rx_valid) begin
                    if (w_cls != CLS_CONT) begin
                        w_emit      = 1'b1;
                        w_emit_err  = 1'b1;
                        w_emit_data = REPL_CHAR;
                        w_pend_nx   = rx_data;
                        w_state_nx  = REPLAY;
                    end else if (r_state == GOT1) begin
                        w_b1_nx    = rx_data;
                        w_state_nx = GOT2;
                    end else begin
                        w_emit     = 1'b1;
                        w_state_nx = IDLE;
`ifdef THAI_RANGE_CHECK_EN
                        if (thai_ok(r_b0, r_b1)) begin
                            w_emit_data = {r_b0, r_b1, rx_data};
                        end else begin
                            w_emit_err  = 1'b1;
                            w_emit_data = REPL_CHAR;
                        end
`else
                        w_emit_data = {r_b0, r_b1, rx_data};
`endif
                    end
                end else if (w_tc) begin
                    w_emit      = 1'b1;
                    w_emit_err  = 1'b1;
                    w_emit_data = REPL_CHAR;
                    w_state_nx  = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_b0       <= '0;
            r_b1       <= '0;
            r_pend     <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_b0       <= w_b0_nx;
            r_b1       <= w_b1_nx;
            r_pend     <= w_pend_nx;
            r_tx_start <= w_emit;
            r_err      <= w_emit & w_emit_err;
            if (w_emit) begin
                r_tx_data <= w_emit_data;
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign err_pulse = r_err;
    assign busy      = w_busy;

endmodule

// File: tb/tb_utf8_char_assembler.sv
// Scoreboard bench for utf8_char_assembler: expected words are queued with their strobe cycle.
module tb_utf8_char_assembler;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] tx_data;
    logic        tx_start;
    logic        err_pulse;
    logic        busy;

    typedef struct {
        logic [23:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t q[$];
    exp_t x;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    utf8_char_assembler #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (5),
        .REPL_CHAR      (24'h00003F)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .err_pulse (err_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at a negedge; the byte is sampled on the next posedge (cycle cyc+1)
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [23:0] d, input logic e, input int c);
        exp_t t;
        t.d = d;
        t.e = e;
        t.c = c;
        q.push_back(t);
    endtask

    always @(posedge clk) begin
        #1;
        if (tx_start) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {31'b0, tx_start}, 32'd0);
            end else begin
                x = q.pop_front();
                check("tx_data", {8'b0, tx_data}, {8'b0, x.d});
                check("err_pulse", {31'b0, err_pulse}, {31'b0, x.e});
                check("latency_cycle", cyc, x.c);
            end
        end else begin
            check("err_without_strobe", {31'b0, err_pulse}, 32'd0);
        end
    end

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check("rst_tx_data", {8'b0, tx_data}, 32'd0);
        check("rst_tx_start", {31'b0, tx_start}, 32'd0);
        check("rst_err", {31'b0, err_pulse}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        idle(2);

        // Plain ASCII
        push(24'h000048, 1'b0, cyc + 1);
        send(8'h48);
        idle(2);
        push(24'h000069, 1'b0, cyc + 1);
        send(8'h69);
        idle(3);

        // Thai "ko kai"
        send(8'hE0);
        check("busy_after_lead", {31'b0, busy}, 32'd1);
        idle(2);
        send(8'hB8);
        check("busy_after_b1", {31'b0, busy}, 32'd1);
        idle(2);
        push(24'hE0B881, 1'b0, cyc + 1);
        send(8'h81);
        check("busy_after_char", {31'b0, busy}, 32'd0);
        idle(3);

        // Truncated sequence followed by ASCII: replacement then replayed byte
        send(8'hE0);
        idle(2);
        push(24'h00003F, 1'b1, cyc + 1);
        push(24'h000041, 1'b0, cyc + 2);
        send(8'h41);
        check("busy_replay", {31'b0, busy}, 32'd0);
        idle(3);
        check("busy_after_replay", {31'b0, busy}, 32'd0);

        // Stray continuation byte in IDLE
        push(24'h00003F, 1'b1, cyc + 1);
        send(8'h85);
        idle(3);

        // Timeout: replacement exactly TO cycles after the last byte
        send(8'hE0);
        idle(2);
        send(8'hB8);
        push(24'h00003F, 1'b1, cyc + TO);
        idle(TO + 4);
        check("busy_after_timeout", {31'b0, busy}, 32'd0);

        // Byte arriving on the expiry cycle wins over the timeout
        send(8'hE0);
        idle(2);
        send(8'hB8);
        idle(TO - 1);
        push(24'hE0B881, 1'b0, cyc + 1);
        send(8'h81);
        idle(TO + 4);

        // Reset mid-sequence discards partial bytes
        send(8'hE0);
        idle(2);
        send(8'hB8);
        idle(2);
        reset = 1'b0;
        idle(2);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_tx_start", {31'b0, tx_start}, 32'd0);
        reset = 1'b1;
        idle(2);
        push(24'h000041, 1'b0, cyc + 1);
        send(8'h41);
        idle(3);

        // Well-formed sequence outside the Thai block
        send(8'hE0);
        idle(2);
        send(8'hA4);
        idle(2);
`ifdef THAI_RANGE_CHECK_EN
        push(24'h00003F, 1'b1, cyc + 1);
`else
        push(24'hE0A480, 1'b0, cyc + 1);
`endif
        send(8'h80);
        idle(3);

        // 2-byte lead is not supported
        push(24'h00003F, 1'b1, cyc + 1);
        send(8'hC3);
        idle(5);

        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
